// File: rtl/bytebeat_pcm_mixer.sv
// Mixes NUM_CH bytebeat PCM streams into one saturated 8-bit sample per sample_tick.
// Define MIXER_LPF_EN to add a one-pole smoothing stage (FILT) after scaling.
module bytebeat_pcm_mixer #(
  parameter int unsigned NUM_CH    = 8,
  parameter int unsigned LPF_SHIFT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_tick,
  input  logic [NUM_CH-1:0]     ch_mask,
  input  logic [2:0]            vol_shift,
  input  logic [8*NUM_CH-1:0]   pcm_in,
  input  logic [NUM_CH-1:0]     pcm_vld,
  output logic [NUM_CH-1:0]     pcm_rdy,
  output logic [7:0]            sample_out,
  output logic                  sample_vld,
  output logic                  busy,
  output logic                  overrun
);

  localparam int unsigned IW = $clog2(NUM_CH);
  localparam int unsigned AW = 8 + IW;

  if (NUM_CH < 2 || NUM_CH > 16 || LPF_SHIFT > 8) begin : g_bad_cfg
    $error("bytebeat_pcm_mixer: unsupported NUM_CH or LPF_SHIFT");
  end

`ifdef MIXER_LPF_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, SCALE = 2'd2, FILT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, SCALE = 2'd2} state_t;
`endif

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] idx;
  logic [AW-1:0] acc;
  logic [AW-1:0] shifted;
  logic [7:0]    pcm_sel;
  logic [7:0]    x;
  logic          take;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (sample_tick) state_nxt = SCAN;
      SCAN:  if (idx == IW'(NUM_CH - 1)) state_nxt = SCALE;
`ifdef MIXER_LPF_EN
      SCALE: state_nxt = FILT;
      FILT:  state_nxt = IDLE;
`else
      SCALE: state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Channel handshake, busy flag and the scaled/saturated mix value.
  always_comb begin
    pcm_rdy = '0;
    pcm_sel = pcm_in[{idx, 3'b000} +: 8];
    take    = (state == SCAN) && ch_mask[idx] && pcm_vld[idx];
    if (take) pcm_rdy[idx] = 1'b1;
    busy    = (state != IDLE);
    shifted = acc >> vol_shift;
    x       = (shifted > AW'(255)) ? 8'hFF : shifted[7:0];
  end

`ifdef MIXER_LPF_EN
  logic [7:0]        x_q;
  logic [7:0]        y;
  logic [7:0]        y_nxt;
  logic signed [9:0] diff;
  logic signed [9:0] step;

  // y moves toward x by 2^-LPF_SHIFT of the signed difference.
  always_comb begin
    diff  = $signed({2'b00, x_q}) - $signed({2'b00, y});
    step  = diff >>> LPF_SHIFT;
    y_nxt = 8'($unsigned(step) + {2'b00, y});
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc        <= '0;
      idx        <= '0;
      sample_out <= 8'd0;
      sample_vld <= 1'b0;
      overrun    <= 1'b0;
`ifdef MIXER_LPF_EN
      x_q        <= 8'd0;
      y          <= 8'd0;
`endif
    end else begin
      sample_vld <= 1'b0;
      if (sample_tick && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (sample_tick) begin
            acc <= '0;
            idx <= '0;
          end
        end
        SCAN: begin
          if (take) acc <= acc + AW'(pcm_sel);
          idx <= idx + IW'(1);
        end
        SCALE: begin
`ifdef MIXER_LPF_EN
          x_q <= x;
`else
          sample_out <= x;
          sample_vld <= 1'b1;
`endif
        end
`ifdef MIXER_LPF_EN
        FILT: begin
          y          <= y_nxt;
          sample_out <= y_nxt;
          sample_vld <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
